// File: rtl/uart_rx_fifo_ctrl.sv
// uart_rx_fifo_ctrl: RX FIFO sequencing (push skid, pop, overrun, 16550 char timeout, RX irqs).
// Build with UART_RX_TIMEOUT_EN defined to include the character-timeout counter and TIMEOUT state.
module uart_rx_fifo_ctrl #(
  parameter int TICKS_PER_CHAR = 160,
  parameter int TIMEOUT_CHARS  = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_tick_i,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_data_i,
  input  logic       rbr_rd_i,
  input  logic       lsr_rd_i,
  input  logic       fcr_rx_reset_i,
  input  logic       ier_rda_en_i,
  input  logic       ier_rls_en_i,
  input  logic [7:0] fifo_data_i,
  input  logic       fifo_empty_i,
  input  logic       fifo_full_i,
  input  logic       fifo_triggered_i,
  output logic       fifo_push_o,
  output logic [7:0] fifo_data_o,
  output logic       fifo_pop_o,
  output logic       fifo_reset_o,
  output logic [7:0] rbr_data_o,
  output logic       lsr_dr_o,
  output logic       lsr_oe_o,
  output logic       irq_rda_o,
  output logic       irq_timeout_o,
  output logic       irq_rls_o
);
  typedef enum logic [1:0] {IDLE, ARMED, TIMEOUT} state_e;
  state_e     state_q, state_d;
  logic       skid_vld_q, skid_vld_d;
  logic [7:0] skid_data_q, skid_data_d;
  logic       oe_q, oe_d;
  logic       fifo_reset_q;
  logic       drain, skid_busy, full_drop, rx_drop;
  assign fifo_pop_o  = rbr_rd_i & ~fifo_empty_i;
  assign rbr_data_o  = fifo_empty_i ? 8'h00 : fifo_data_i;
  // The staged byte leaves in any cycle without a pop: pushed if there is room, dropped otherwise.
  assign drain       = skid_vld_q & ~fifo_pop_o;
  assign skid_busy   = skid_vld_q & ~drain;
  assign fifo_push_o = drain & ~fifo_full_i;
  assign fifo_data_o = skid_data_q;
  assign full_drop   = drain & fifo_full_i;
  assign rx_drop     = rx_valid_i & ~fcr_rx_reset_i & skid_busy;
  assign skid_vld_d  = ~fcr_rx_reset_i & (rx_valid_i | skid_busy);
  assign skid_data_d = (rx_valid_i & ~skid_busy) ? rx_data_i : skid_data_q;
  assign oe_d        = full_drop | rx_drop | (oe_q & ~lsr_rd_i);
  assign fifo_reset_o = fifo_reset_q;
  assign lsr_oe_o    = oe_q;
  assign lsr_dr_o    = ~fifo_empty_i;
  assign irq_rda_o   = ier_rda_en_i & fifo_triggered_i;
  assign irq_rls_o   = ier_rls_en_i & oe_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      skid_vld_q   <= 1'b0;
      skid_data_q  <= 8'h00;
      oe_q         <= 1'b0;
      fifo_reset_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      skid_vld_q   <= skid_vld_d;
      skid_data_q  <= skid_data_d;
      oe_q         <= oe_d;
      fifo_reset_q <= fcr_rx_reset_i;
    end
  end
`ifdef UART_RX_TIMEOUT_EN
  localparam int LIMIT = TICKS_PER_CHAR * TIMEOUT_CHARS;
  localparam int CW = $clog2(LIMIT);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          act;
  assign act = fifo_push_o | fifo_pop_o;
  // Counter only advances in ARMED and holds at LAST once TIMEOUT is reached.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (fcr_rx_reset_i || fifo_empty_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == IDLE) begin
      state_d = ARMED;
    end else if (act) begin
      state_d = ARMED;
      cnt_d   = '0;
    end else if (state_q == ARMED && baud_tick_i) begin
      state_d = (cnt_q == LAST) ? TIMEOUT : ARMED;
      cnt_d   = (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
  assign irq_timeout_o = ier_rda_en_i & (state_q == TIMEOUT);
`else
  logic unused_ok;
  always_comb state_d = (fcr_rx_reset_i | fifo_empty_i) ? IDLE : (state_q == IDLE ? ARMED : state_q);
  assign unused_ok     = baud_tick_i ^ (TICKS_PER_CHAR * TIMEOUT_CHARS == 0);
  assign irq_timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// tb_uart_rx_fifo_ctrl: scoreboard bench with a 16-deep FIFO model (trigger level 4).
module tb_uart_rx_fifo_ctrl;
`ifdef UART_RX_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b0;
  logic baud_tick = 0, rx_valid = 0, rbr_rd = 0, lsr_rd = 0, fcr_rst = 0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] fifo_data_i, fifo_data_o, rbr_data;
  logic fifo_empty, fifo_full, fifo_trig;
  logic fifo_push, fifo_pop, fifo_reset, lsr_dr, lsr_oe, irq_rda, irq_to, irq_rls;
  logic done = 1'b0;
  always #5 clk = ~clk;
  uart_rx_fifo_ctrl dut (
    .clk(clk), .reset_n(reset_n), .baud_tick_i(baud_tick), .rx_valid_i(rx_valid),
    .rx_data_i(rx_data), .rbr_rd_i(rbr_rd), .lsr_rd_i(lsr_rd), .fcr_rx_reset_i(fcr_rst),
    .ier_rda_en_i(1'b1), .ier_rls_en_i(1'b1), .fifo_data_i(fifo_data_i),
    .fifo_empty_i(fifo_empty), .fifo_full_i(fifo_full), .fifo_triggered_i(fifo_trig),
    .fifo_push_o(fifo_push), .fifo_data_o(fifo_data_o), .fifo_pop_o(fifo_pop),
    .fifo_reset_o(fifo_reset), .rbr_data_o(rbr_data), .lsr_dr_o(lsr_dr), .lsr_oe_o(lsr_oe),
    .irq_rda_o(irq_rda), .irq_timeout_o(irq_to), .irq_rls_o(irq_rls)
  );
  logic [7:0] mem [16];
  int cnt;
  assign fifo_empty  = (cnt == 0);
  assign fifo_full   = (cnt == 16);
  assign fifo_trig   = (cnt >= 4);
  assign fifo_data_i = mem[0];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= 0;
    else if (fifo_reset) cnt <= 0;
    else if (fifo_pop) begin
      for (int i = 0; i < 15; i++) mem[i] <= mem[i+1];
      cnt <= cnt - 1;
    end else if (fifo_push && cnt < 16) begin
      mem[cnt] <= fifo_data_o;
      cnt <= cnt + 1;
    end
  end
  logic [7:0] exp_push [$];
  logic [8:0] exp_rd [$];
  string      st_name [$];
  logic [7:0] st_mask [$], st_val [$];
  logic [7:0] stv;
  assign stv = {fifo_push, fifo_pop, fifo_reset, lsr_dr, lsr_oe, irq_rda, irq_to, irq_rls};
  int checks = 0, errors = 0;
  logic fin = 1'b0;
  string n;
  logic [7:0] m, v, e;
  logic [8:0] er;
  always @(negedge clk) begin
    while (st_val.size() > 0) begin
      n = st_name.pop_front(); m = st_mask.pop_front(); v = st_val.pop_front();
      checks++;
      if ((stv & m) !== (v & m)) begin
        errors++;
        $display("FAIL %s status act=%b exp=%b mask=%b", n, stv, v, m);
      end
    end
    if (reset_n) begin
      if (fifo_push | fifo_pop) begin
        checks++;
        if (fifo_push & fifo_pop) begin errors++; $display("FAIL push_pop_overlap act=11 exp=not both"); end
      end
      if (fifo_push) begin
        checks++;
        if (exp_push.size() == 0) begin errors++; $display("FAIL unexpected_push act=%h exp=none", fifo_data_o); end
        else begin
          e = exp_push.pop_front();
          if (fifo_data_o !== e) begin errors++; $display("FAIL push_data act=%h exp=%h", fifo_data_o, e); end
        end
      end
      if (rbr_rd) begin
        checks++;
        if (exp_rd.size() == 0) begin errors++; $display("FAIL unexpected_read act=%h exp=none", {fifo_pop, rbr_data}); end
        else begin
          er = exp_rd.pop_front();
          if ({fifo_pop, rbr_data} !== er) begin errors++; $display("FAIL read pop/data act=%h exp=%h", {fifo_pop, rbr_data}, er); end
        end
      end
    end
    if (done && !fin) begin
      fin = 1'b1;
      checks += 2;
      if (exp_push.size() != 0) begin errors++; $display("FAIL missing_push act=%0d left exp=0", exp_push.size()); end
      if (exp_rd.size() != 0) begin errors++; $display("FAIL missing_read act=%0d left exp=0", exp_rd.size()); end
    end
  end
  task automatic cyc(input logic rx, input logic [7:0] d, input logic rd, input logic lrd, input logic fcr, input logic bt);
    rx_valid = rx; rx_data = d; rbr_rd = rd; lsr_rd = lrd; fcr_rst = fcr; baud_tick = bt;
    @(posedge clk); #1;
    rx_valid = 0; rbr_rd = 0; lsr_rd = 0; fcr_rst = 0; baud_tick = 0;
  endtask
  task automatic idle(input int k);
    repeat (k) cyc(0, 8'h00, 0, 0, 0, 0);
  endtask
  task automatic ticks(input int k);
    repeat (k) cyc(0, 8'h00, 0, 0, 0, 1);
  endtask
  task automatic put(input logic [7:0] d, input bit keep);
    if (keep) exp_push.push_back(d);
    cyc(1, d, 0, 0, 0, 0);
    idle(3);
  endtask
  task automatic rd(input logic [8:0] ex);
    exp_rd.push_back(ex);
    cyc(0, 8'h00, 1, 0, 0, 0);
  endtask
  task automatic rx_rd(input logic [7:0] d, input bit keep, input logic [8:0] ex);
    if (keep) exp_push.push_back(d);
    exp_rd.push_back(ex);
    cyc(1, d, 1, 0, 0, 0);
  endtask
  task automatic expect_st(input string nm, input logic [7:0] mk, input logic [7:0] vl);
    st_name.push_back(nm); st_mask.push_back(mk); st_val.push_back(vl);
    idle(1);
  endtask
  initial begin
    expect_st("reset", 8'hFF, 8'h00);
    reset_n = 1'b1;
    idle(1);
    put(8'h11, 1); put(8'h22, 1); put(8'h33, 1);
    expect_st("three_held", 8'h18, 8'h10);
    cyc(1, 8'h44, 0, 0, 0, 0);
    reset_n = 1'b0;
    expect_st("mid_reset", 8'hFF, 8'h00);
    reset_n = 1'b1;
    idle(2);
    expect_st("after_reset", 8'hFF, 8'h00);
    put(8'h11, 1);
    rx_rd(8'hA5, 1, {1'b1, 8'h11});
    rd({1'b0, 8'h00});
    idle(2);
    put(8'h66, 1);
    rx_rd(8'h77, 1, {1'b1, 8'hA5});
    rd({1'b1, 8'h66});
    idle(2);
    rd({1'b1, 8'h77});
    idle(1);
    expect_st("drained", 8'h18, 8'h00);
    put(8'h81, 1); put(8'h82, 1);
    rx_rd(8'h83, 1, {1'b1, 8'h81});
    rx_rd(8'h84, 0, {1'b1, 8'h82});
    expect_st("skid_overrun", 8'h09, 8'h09);
    cyc(0, 8'h00, 0, 1, 0, 0);
    expect_st("oe_clear", 8'h09, 8'h00);
    rd({1'b1, 8'h83});
    idle(1);
    for (int i = 0; i < 16; i++) put(8'h20 + 8'(i), 1);
    put(8'h30, 0);
    expect_st("full_overrun", 8'h1D, 8'h1D);
    cyc(0, 8'h00, 0, 1, 0, 0);
    expect_st("oe_clear2", 8'h09, 8'h00);
    cyc(1, 8'h99, 0, 0, 0, 0);
    cyc(0, 8'h00, 0, 1, 0, 0);
    expect_st("set_wins", 8'h08, 8'h08);
    for (int i = 0; i < 11; i++) rd({1'b1, 8'h20 + 8'(i)});
    ticks(639);
    expect_st("pre_timeout", 8'h02, 8'h00);
    ticks(1);
    expect_st("timeout_five", 8'h06, {5'b0, 1'b1, TO_EN, 1'b0});
    cyc(0, 8'h00, 0, 0, 1, 0);
    expect_st("fcr_pulse", 8'h2A, 8'h28);
    expect_st("fcr_done", 8'h38, 8'h08);
    cyc(0, 8'h00, 0, 1, 0, 0);
    cyc(1, 8'h55, 0, 0, 1, 0);
    idle(2);
    expect_st("fcr_discard", 8'hFF, 8'h00);
    put(8'hC3, 1);
    ticks(640);
    expect_st("timeout_single", 8'h12, {3'b0, 1'b1, 2'b0, TO_EN, 1'b0});
    rd({1'b1, 8'hC3});
    expect_st("timeout_cleared", 8'h12, 8'h00);
    put(8'hD1, 1);
    ticks(639);
    put(8'hD2, 1);
    ticks(639);
    expect_st("restart_hold", 8'h02, 8'h00);
    ticks(1);
    expect_st("restart_timeout", 8'h02, {6'b0, TO_EN, 1'b0});
    rd({1'b1, 8'hD1});
    rd({1'b1, 8'hD2});
    idle(2);
    done = 1'b1;
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
